// File: rtl/tdm_frame_ctrl.sv
// TDM frame scheduler: grants N_CH bit-serial requesters one two-cycle slot per frame.
// Optional sync preamble ahead of each frame is enabled with `define TDM_FRAME_SYNC_EN.
module tdm_frame_ctrl #(
  parameter int unsigned         N_CH      = 2,
  parameter int unsigned         SYNC_LEN  = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1110,
  parameter logic                IDLE_BIT  = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_CH-1:0]           ch_valid,
  input  logic [N_CH-1:0]           ch_data,
  output logic [N_CH-1:0]           ch_ready,
  output logic [N_CH-1:0]           ch_miss,
  output logic                      enc_bit,
  output logic                      enc_phase,
  output logic                      enc_act,
  output logic [$clog2(N_CH)-1:0]   slot,
  output logic                      in_sync,
  output logic                      frame_start
);
  localparam int unsigned CW = 3;
  localparam int unsigned SW = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, START, SYNC, DATA} state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0] ready_q, ready_d, miss_q, miss_d;
  logic            bit_q, bit_d, act_q, act_d, sync_q, sync_d, fs_q, fs_d;
  logic [SW-1:0]   slot_q, slot_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= '0;
      miss_q  <= '0;
      bit_q   <= 1'b0;
      act_q   <= 1'b0;
      sync_q  <= 1'b0;
      fs_q    <= 1'b0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      miss_q  <= miss_d;
      bit_q   <= bit_d;
      act_q   <= act_d;
      sync_q  <= sync_d;
      fs_q    <= fs_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (en) state_d = START;
      START: begin
        phase_d = 1'b0;
        cnt_d   = '0;
`ifdef TDM_FRAME_SYNC_EN
        state_d = SYNC;
`else
        state_d = DATA;
`endif
      end
`ifdef TDM_FRAME_SYNC_EN
      SYNC: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (cnt_q == CW'(SYNC_LEN - 1)) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (cnt_q == CW'(N_CH - 1)) begin
            cnt_d = '0;
            // Back-to-back frames skip START; the frame always runs to its end.
`ifdef TDM_FRAME_SYNC_EN
            state_d = en ? SYNC : IDLE;
`else
            state_d = en ? DATA : IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    ready_d = '0;
    miss_d  = '0;
    bit_d   = bit_q;
    act_d   = (state_d == SYNC) || (state_d == DATA);
    slot_d  = '0;
    sync_d  = 1'b0;
    fs_d    = 1'b0;
    if (state_d == DATA) slot_d = cnt_d[SW-1:0];
`ifdef TDM_FRAME_SYNC_EN
    sync_d     = (state_d == SYNC);
    fs_d       = (state_d == SYNC) && (cnt_d == '0) && !phase_d;
    ready_d[0] = (state_d == SYNC) && (cnt_d == CW'(SYNC_LEN - 1)) && phase_d;
    if ((state_d == SYNC) && !phase_d) begin
      for (int unsigned k = 0; k < SYNC_LEN; k++) begin
        if (cnt_d == CW'(k)) bit_d = SYNC_WORD[SYNC_LEN-1-k];
      end
    end
`else
    fs_d       = (state_d == DATA) && (cnt_d == '0) && !phase_d;
    ready_d[0] = (state_d == START) ||
                 ((state_d == DATA) && (cnt_d == CW'(N_CH - 1)) && phase_d);
`endif
    for (int unsigned i = 1; i < N_CH; i++) begin
      ready_d[i] = (state_d == DATA) && (cnt_d == CW'(i - 1)) && phase_d;
    end
    if (state_d == DATA) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (ready_q[i]) begin
          bit_d     = ch_valid[i] ? ch_data[i] : IDLE_BIT;
          miss_d[i] = !ch_valid[i];
        end
      end
    end
    if (!act_d) bit_d = 1'b0;
  end

  assign ch_ready    = ready_q;
  assign ch_miss     = miss_q;
  assign enc_bit     = bit_q;
  assign enc_phase   = phase_q;
  assign enc_act     = act_q;
  assign slot        = slot_q;
  assign in_sync     = sync_q;
  assign frame_start = fs_q;
endmodule
